// File: rtl/pll_phase_pkg.sv
// Shared definitions for the rPLL dynamic-phase sweep controller.
package pll_phase_pkg;

  // Width of the rPLL PSDA / DUTYDA buses.
  localparam int PS_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_WAIT_LOCK,
    ST_SETTLE,
    ST_SAMPLE,
    ST_COMPARE,
    ST_PARK
  } state_e;

  // Duty setting that tracks a phase setting: (phase + duty offset) mod 16.
  // The 4-bit result width performs the modulo.
  function automatic logic [PS_W-1:0] duty_of(input logic [PS_W-1:0] phase,
                                              input logic [PS_W-1:0] offset);
    return phase + offset;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level (rPLL LOCK).
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  // Shift the asynchronous input through two flops; resets to "not locked".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/pll_phase_sweep_ctrl.sv
// Sweeps the rPLL dynamic phase through every step, counts phase-detector
// hits per step, then parks the PLL on the step with the most hits.
module pll_phase_sweep_ctrl
  import pll_phase_pkg::*;
#(
  parameter int PHASE_STEPS   = 16,
  parameter int DUTY_STEPS    = 8,
  parameter int SETTLE_CYCLES = 64,
  parameter int SAMPLE_CYCLES = 256,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int CNT_W         = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             lock,
  input  logic             pd_in,
  output logic [PS_W-1:0]  psda,
  output logic [PS_W-1:0]  dutyda,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [PS_W-1:0]  best_phase,
  output logic [CNT_W-1:0] best_count
);

  // One shared timer covers lock wait, settle and sample windows.
  localparam int MAX_LS  = (LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES;
  localparam int TMR_MAX = (MAX_LS > SAMPLE_CYCLES) ? MAX_LS : SAMPLE_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] LOCK_LAST   = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] SAMPLE_LAST = TMR_W'(SAMPLE_CYCLES - 1);
  localparam logic [PS_W-1:0]  LAST_STEP   = PS_W'(PHASE_STEPS - 1);
  localparam logic [PS_W-1:0]  DUTY_OFS    = PS_W'(DUTY_STEPS);

  // Reject parameter sets the datapath cannot honour (counter wrap, PSDA range).
  if (PHASE_STEPS < 1 || PHASE_STEPS > 16 || DUTY_STEPS < 0 || DUTY_STEPS > 15 ||
      SETTLE_CYCLES < 1 || SAMPLE_CYCLES < 1 || LOCK_TIMEOUT < 1 ||
      (2 ** CNT_W) <= SAMPLE_CYCLES) begin : g_bad_params
    $error("pll_phase_sweep_ctrl: parameter out of range");
  end

  logic lock_s;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (lock),
    .q_o   (lock_s)
  );

  state_e           state_q, state_d;
  logic [PS_W-1:0]  step_q, step_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] hits_q, hits_d;
  logic [PS_W-1:0]  psda_q, psda_d;
  logic [PS_W-1:0]  dutyda_q, dutyda_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             terr_q, terr_d;
  logic [PS_W-1:0]  best_phase_q, best_phase_d;
  logic [CNT_W-1:0] best_count_q, best_count_d;

  // State, counters and all outputs are registered; reset parks at phase 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      step_q       <= '0;
      timer_q      <= '0;
      hits_q       <= '0;
      psda_q       <= '0;
      dutyda_q     <= DUTY_OFS;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      terr_q       <= 1'b0;
      best_phase_q <= '0;
      best_count_q <= '0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      timer_q      <= timer_d;
      hits_q       <= hits_d;
      psda_q       <= psda_d;
      dutyda_q     <= dutyda_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      terr_q       <= terr_d;
      best_phase_q <= best_phase_d;
      best_count_q <= best_count_d;
    end
  end

  // Sweep sequencing: apply, wait for lock, settle, sample, compare, park.
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    timer_d      = timer_q;
    hits_d       = hits_q;
    psda_d       = psda_q;
    dutyda_d     = dutyda_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    terr_d       = terr_q;
    best_phase_d = best_phase_q;
    best_count_d = best_count_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_APPLY;
          busy_d       = 1'b1;
          step_d       = '0;
          terr_d       = 1'b0;
          best_phase_d = '0;
          best_count_d = '0;
        end
      end
      ST_APPLY: begin
        psda_d   = step_q;
        dutyda_d = duty_of(step_q, DUTY_OFS);
        timer_d  = '0;
        hits_d   = '0;
        state_d  = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          timer_d = '0;
          state_d = ST_SETTLE;
        end else if (timer_q == LOCK_LAST) begin
          // Unlockable step: flag it and score it as zero hits.
          terr_d  = 1'b1;
          hits_d  = '0;
          state_d = ST_COMPARE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_SETTLE: begin
        if (!lock_s) begin
          timer_d = '0;
          state_d = ST_WAIT_LOCK;
        end else if (timer_q == SETTLE_LAST) begin
          timer_d = '0;
          state_d = ST_SAMPLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_SAMPLE: begin
        if (!lock_s) begin
          // Partial window is worthless; retry the same step from lock wait.
          timer_d = '0;
          hits_d  = '0;
          state_d = ST_WAIT_LOCK;
        end else begin
          hits_d = hits_q + CNT_W'(pd_in);
          if (timer_q == SAMPLE_LAST) begin
            state_d = ST_COMPARE;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
      end
      ST_COMPARE: begin
        // Strict compare so ties keep the lowest step.
        if (hits_q > best_count_q) begin
          best_count_d = hits_q;
          best_phase_d = step_q;
        end
        if (step_q == LAST_STEP) begin
          state_d = ST_PARK;
        end else begin
          step_d  = step_q + PS_W'(1);
          state_d = ST_APPLY;
        end
      end
      ST_PARK: begin
        psda_d   = best_phase_q;
        dutyda_d = duty_of(best_phase_q, DUTY_OFS);
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign psda        = psda_q;
  assign dutyda      = dutyda_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = terr_q;
  assign best_phase  = best_phase_q;
  assign best_count  = best_count_q;

endmodule

// File: tb/tb_pll_phase_sweep_ctrl.sv
// Randomised scoreboard bench for pll_phase_sweep_ctrl with small parameters.
module tb_pll_phase_sweep_ctrl;

  localparam int NS = 4;
  localparam int DS = 8;
  localparam int SC = 4;
  localparam int MC = 8;
  localparam int LT = 16;
  localparam int CW = 4;
  localparam int PLAN_LEN = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          lock = 1'b1;
  logic          pd_in = 1'b0;
  logic [3:0]    psda;
  logic [3:0]    dutyda;
  logic          busy;
  logic          done;
  logic          timeout_err;
  logic [3:0]    best_phase;
  logic [CW-1:0] best_count;

  pll_phase_sweep_ctrl #(
    .PHASE_STEPS   (NS),
    .DUTY_STEPS    (DS),
    .SETTLE_CYCLES (SC),
    .SAMPLE_CYCLES (MC),
    .LOCK_TIMEOUT  (LT),
    .CNT_W         (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .lock        (lock),
    .pd_in       (pd_in),
    .psda        (psda),
    .dutyda      (dutyda),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .best_phase  (best_phase),
    .best_count  (best_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int bp;
    int bc;
    int te;
    int t_done;
  } exp_t;

  exp_t sb_q[$];

  // Step plan: 0 = locks at once, 1 = never locks (timeout), 2 = lock lost 3 cycles into SAMPLE.
  int kind [NS];
  int win  [NS];
  bit pd_plan   [PLAN_LEN];
  bit lock_plan [PLAN_LEN];   // index = cycle + 1, so cycle -1 (start cycle) is entry 0
  int park_c;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Cycle 0 is the APPLY cycle of step 0 (first cycle after start is taken).
  // Derives each step's counted sample window and the lock waveform from the
  // state durations: APPLY 1, WAIT_LOCK t_lock (1 with lock present), SETTLE SC,
  // SAMPLE MC, COMPARE 1; a timed-out step is APPLY 1 + LT + COMPARE 1.
  task automatic plan_schedule();
    int a;
    int w;
    a = 0;
    for (int i = 0; i < PLAN_LEN; i++) lock_plan[i] = 1'b1;
    for (int s = 0; s < NS; s++) begin
      if (kind[s] == 1) begin
        win[s] = -1;
        for (int c = a - 1; c <= a + LT - 2; c++) lock_plan[c + 1] = 1'b0;
        a = a + LT + 2;
      end else if (kind[s] == 2) begin
        w = a + 2 + SC;
        lock_plan[w + 2] = 1'b0;          // synchronised lock is low in the 4th sample cycle
        win[s] = w + 4 + 1 + SC;          // 3 counted + 1 dropped, 1 wait, resettle
        a = win[s] + MC + 1;
      end else begin
        win[s] = a + 2 + SC;
        a = a + 3 + SC + MC;
      end
    end
    park_c = a;
  endtask

  task automatic random_pd(input int dens);
    for (int i = 0; i < PLAN_LEN; i++) pd_plan[i] = ($urandom_range(0, 99) < dens);
  endtask

  // Reference: hits per step over its final window, strict argmax from step 0.
  task automatic model(output exp_t e);
    int h;
    e.bp = 0;
    e.bc = 0;
    e.te = 0;
    for (int s = 0; s < NS; s++) begin
      h = 0;
      if (kind[s] == 1) e.te = 1;
      else for (int i = 0; i < MC; i++) h += int'(pd_plan[win[s] + i]);
      if (h > e.bc) begin
        e.bc = h;
        e.bp = s;
      end
    end
    e.t_done = 0;
  endtask

  // Runs one planned sweep; extra_start_c >= 0 re-pulses start mid-sweep.
  task automatic run_sweep(input string tag, input int extra_start_c);
    exp_t e;
    model(e);
    @(posedge clk);
    #1;
    lock  = lock_plan[0];
    start = 1'b1;
    pd_in = 1'b0;
    @(posedge clk);
    #1;
    start    = 1'b0;
    e.t_done = cyc + park_c + 1;
    sb_q.push_back(e);
    check({tag, "_busy_after_start"}, int'(busy), 1);
    check({tag, "_terr_cleared"}, int'(timeout_err), 0);
    for (int c = 0; c <= park_c; c++) begin
      pd_in = pd_plan[c];
      lock  = lock_plan[c + 1];
      start = (c == extra_start_c);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    pd_in = 1'b0;
    lock  = 1'b1;
    for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(posedge clk);
    check({tag, "_done_pending"}, sb_q.size(), 0);
    sb_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_no_restart_busy"}, int'(busy), 0);
    $display("sweep %s: best_phase=%0d best_count=%0d timeout_err=%0d", tag, e.bp, e.bc, e.te);
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1, expected 0 (t=%0t)", $time);
        end else begin
          e = sb_q.pop_front();
          check("done_cycle", cyc, e.t_done);
          check("best_phase", int'(best_phase), e.bp);
          check("best_count", int'(best_count), e.bc);
          check("timeout_err", int'(timeout_err), e.te);
          check("psda_parked", int'(psda), e.bp);
          check("dutyda_parked", int'(dutyda), (e.bp + DS) % 16);
          check("busy_at_done", int'(busy), 0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_psda", int'(psda), 0);
    check("rst_dutyda", int'(dutyda), DS);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_terr", int'(timeout_err), 0);
    check("rst_best_phase", int'(best_phase), 0);
    check("rst_best_count", int'(best_count), 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Hits only around step 2.
    for (int s = 0; s < NS; s++) kind[s] = 0;
    plan_schedule();
    for (int i = 0; i < PLAN_LEN; i++) pd_plan[i] = 1'b0;
    for (int c = 30; c < 45; c++) pd_plan[c] = 1'b1;
    run_sweep("only_step2", -1);

    // Five hits at steps 1 and 3: tie keeps step 1.
    for (int i = 0; i < PLAN_LEN; i++) pd_plan[i] = 1'b0;
    for (int i = 0; i < 5; i++) pd_plan[win[1] + i] = 1'b1;
    for (int i = 2; i < 7; i++) pd_plan[win[3] + i] = 1'b1;
    run_sweep("tie", -1);

    // All zero hits.
    for (int i = 0; i < PLAN_LEN; i++) pd_plan[i] = 1'b0;
    run_sweep("zero", -1);

    // Step 1 never locks; pd_in high throughout it must not count.
    kind[1] = 1;
    plan_schedule();
    for (int i = 0; i < PLAN_LEN; i++) pd_plan[i] = 1'b0;
    for (int c = 15; c < 33; c++) pd_plan[c] = 1'b1;
    for (int i = 0; i < 3; i++) pd_plan[win[3] + i] = 1'b1;
    run_sweep("timeout", -1);

    // Start pulsed mid-sweep is ignored; new start cleared timeout_err.
    kind[1] = 0;
    plan_schedule();
    random_pd(50);
    run_sweep("busy_start", 20);

    // Lock lost 3 cycles into SAMPLE of step 0 with pd_in always high.
    kind[0] = 2;
    plan_schedule();
    for (int i = 0; i < PLAN_LEN; i++) pd_plan[i] = 1'b1;
    run_sweep("lock_drop", -1);

    // Randomised sweeps.
    for (int r = 0; r < 8; r++) begin
      int pick;
      for (int s = 0; s < NS; s++) begin
        pick = $urandom_range(0, 99);
        kind[s] = (pick < 70) ? 0 : ((pick < 85) ? 1 : 2);
      end
      plan_schedule();
      random_pd($urandom_range(10, 90));
      run_sweep($sformatf("rand%0d", r), ($urandom_range(0, 1) == 1) ? $urandom_range(0, park_c) : -1);
    end

    // Reset mid-SAMPLE of step 2.
    for (int s = 0; s < NS; s++) kind[s] = 0;
    plan_schedule();
    random_pd(50);
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c < win[2] + 2; c++) begin
      pd_in = pd_plan[c];
      @(posedge clk);
      #1;
    end
    check("psda_before_reset", int'(psda), 2);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_psda", int'(psda), 0);
    check("arst_dutyda", int'(dutyda), DS);
    check("arst_busy", int'(busy), 0);
    check("arst_best_count", int'(best_count), 0);
    $display("reset mid-sample: psda=%0d dutyda=%0d busy=%0d", psda, dutyda, busy);
    pd_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    random_pd(60);
    run_sweep("after_reset", -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
